// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder
// DATA_WIDTH-bit adder/subtractor split into STAGE_WIDTH-bit chunks.
// Each pipeline stage ripples one chunk and registers its carry into the next
// stage, so the critical path is one chunk wide regardless of DATA_WIDTH.
// Valid/ready stream handshake with full backpressure. A stall freezes every
// stage at once, and bubbles are not compressed.
module pipelined_carry_adder #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAGE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] carry_vec
);

  localparam int STAGES = DATA_WIDTH / STAGE_WIDTH;
  localparam int LAST   = STAGES - 1;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry bit (majority of the three inputs).
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Pipeline registers. Entry k holds the beat after chunk k is resolved.
  // Operands travel along so that later stages can consume their chunks.
  logic                  r_v   [STAGES];
  logic [DATA_WIDTH-1:0] r_a   [STAGES];
  logic [DATA_WIDTH-1:0] r_b   [STAGES];
  logic [DATA_WIDTH-1:0] r_sum [STAGES];
  logic [DATA_WIDTH-1:0] r_cv  [STAGES];
  logic                  r_c   [STAGES];
  logic                  r_ovf;

  // Effective operands and the stall decision.
  logic                  w_stall;
  logic [DATA_WIDTH-1:0] w_b_eff;
  logic                  w_c0;

  // Inputs seen by each stage: the ports for stage 0, otherwise the registers
  // of the previous stage.
  logic                  w_stg_v   [STAGES];
  logic [DATA_WIDTH-1:0] w_stg_a   [STAGES];
  logic [DATA_WIDTH-1:0] w_stg_b   [STAGES];
  logic [DATA_WIDTH-1:0] w_stg_sum [STAGES];
  logic [DATA_WIDTH-1:0] w_stg_cv  [STAGES];
  logic                  w_stg_cin [STAGES];

  // Values each stage will register when the pipe advances.
  logic [DATA_WIDTH-1:0] w_nxt_sum [STAGES];
  logic [DATA_WIDTH-1:0] w_nxt_cv  [STAGES];
  logic                  w_nxt_c   [STAGES];
  logic                  w_carry;

  // Operand conditioning: subtraction is a + ~b + 1. Also decides the stall.
  always_comb begin
    w_b_eff = sub ? ~b : b;
    w_c0    = sub ? 1'b1 : cin;
    w_stall = r_v[LAST] && !out_ready;
  end

  // Route each stage's inputs from the ports (stage 0) or the previous stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        w_stg_v[k]   = in_valid;
        w_stg_a[k]   = a;
        w_stg_b[k]   = w_b_eff;
        w_stg_sum[k] = '0;
        w_stg_cv[k]  = '0;
        w_stg_cin[k] = w_c0;
      end else begin
        // The index guard keeps the unused branch in range when STAGES == 1.
        w_stg_v[k]   = r_v[(k == 0) ? 0 : k - 1];
        w_stg_a[k]   = r_a[(k == 0) ? 0 : k - 1];
        w_stg_b[k]   = r_b[(k == 0) ? 0 : k - 1];
        w_stg_sum[k] = r_sum[(k == 0) ? 0 : k - 1];
        w_stg_cv[k]  = r_cv[(k == 0) ? 0 : k - 1];
        w_stg_cin[k] = r_c[(k == 0) ? 0 : k - 1];
      end
    end
  end

  // Ripple chunk k through STAGE_WIDTH full adders. Chunks finished by earlier
  // stages pass through unchanged.
  always_comb begin
    w_carry = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      w_nxt_sum[k] = w_stg_sum[k];
      w_nxt_cv[k]  = w_stg_cv[k];
      w_carry      = w_stg_cin[k];
      for (int j = 0; j < STAGE_WIDTH; j++) begin
        w_nxt_cv[k][k * STAGE_WIDTH + j]  = w_carry;
        w_nxt_sum[k][k * STAGE_WIDTH + j] = fa_sum(w_stg_a[k][k * STAGE_WIDTH + j],
                                                   w_stg_b[k][k * STAGE_WIDTH + j],
                                                   w_carry);
        w_carry = fa_carry(w_stg_a[k][k * STAGE_WIDTH + j],
                           w_stg_b[k][k * STAGE_WIDTH + j],
                           w_carry);
      end
      w_nxt_c[k] = w_carry;
    end
  end

  // Pipeline advance. Reset clears everything. A stall freezes every stage.
  // Data registers load only for valid beats, so bubbles do not disturb
  // the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_cv[k]  <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_stg_v[k];
        if (w_stg_v[k]) begin
          r_a[k]   <= w_stg_a[k];
          r_b[k]   <= w_stg_b[k];
          r_sum[k] <= w_nxt_sum[k];
          r_cv[k]  <= w_nxt_cv[k];
          r_c[k]   <= w_nxt_c[k];
        end
      end
      // Signed overflow: carry into the MSB differs from carry out of it.
      if (w_stg_v[LAST]) begin
        r_ovf <= w_nxt_cv[LAST][DATA_WIDTH-1] ^ w_nxt_c[LAST];
      end
    end
  end

  // in_ready looks only at the registered output valid and at out_ready.
  assign in_ready  = !w_stall;
  assign out_valid = r_v[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_c[LAST];
  assign overflow  = r_ovf;
  assign carry_vec = r_cv[LAST];

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (DATA_WIDTH=8, STAGE_WIDTH=4).
// Reference model: plain integer arithmetic plus a queue of expected results.
module tb_pipelined_carry_adder;

  localparam int DW     = 8;
  localparam int SW     = 4;
  localparam int STAGES = DW / SW;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
    logic [DW-1:0] cv;
  } res_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          cout;
  logic          overflow;
  logic [DW-1:0] carry_vec;

  int   checks;
  int   errors;
  int   delivered;
  res_t exp_q[$];

  logic          prev_stall;
  logic [DW-1:0] prev_sum;
  logic [DW-1:0] prev_cv;
  logic          prev_cout;
  logic          prev_ovf;
  logic          prev_ov;

  pipelined_carry_adder #(.DATA_WIDTH(DW), .STAGE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .carry_vec(carry_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact (DW+1)-bit sum, carries recovered from a^b^sum,
  // overflow from a signed range check.
  function automatic res_t model(input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                                 input logic ci, input logic si);
    logic [DW-1:0] be;
    logic          c0;
    logic [DW:0]   full;
    longint        sv;
    longint        hi;
    longint        lo;
    res_t          r;
    be     = si ? ~bi : bi;
    c0     = si ? 1'b1 : ci;
    full   = {1'b0, ai} + {1'b0, be} + {{DW{1'b0}}, c0};
    r.sum  = full[DW-1:0];
    r.cout = full[DW];
    r.cv   = ai ^ be ^ r.sum;
    sv     = longint'($signed(ai)) + longint'($signed(be)) + longint'(c0);
    hi     = (longint'(1) <<< (DW - 1)) - 1;
    lo     = -hi - 1;
    r.ovf  = (sv > hi) || (sv < lo);
    return r;
  endfunction

  // One clock cycle: drive inputs, sample mid-cycle, update scoreboard.
  task automatic cycle(input logic v, input logic [DW-1:0] ai, input logic [DW-1:0] bi,
                       input logic ci, input logic si, input logic ordy, input logic rs,
                       output logic acc);
    res_t e;
    rst = rs; in_valid = v; a = ai; b = bi; cin = ci; sub = si; out_ready = ordy;
    @(negedge clk);
    acc = 1'b0;
    if (!rs) begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, prev_ov);
        chk("stall_hold_sum", sum, prev_sum);
        chk("stall_hold_cout", cout, prev_cout);
        chk("stall_hold_ovf", overflow, prev_ovf);
        chk("stall_hold_cv", carry_vec, prev_cv);
      end
      if (out_valid && out_ready) begin
        chk("pending_beat", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          delivered++;
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("overflow", overflow, e.ovf);
          chk("carry_vec", carry_vec, e.cv);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ai, bi, ci, si));
        acc = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_ov = out_valid; prev_sum = sum; prev_cout = cout;
      prev_ovf = overflow; prev_cv = carry_vec;
    end else begin
      exp_q.delete();
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Single isolated beat with latency check and fixed expected values.
  task automatic directed(input logic [DW-1:0] ai, input logic [DW-1:0] bi, input logic ci,
                          input logic si, input logic [DW-1:0] es, input logic ec,
                          input logic eo, input logic [DW-1:0] ecv);
    logic acc;
    cycle(1'b1, ai, bi, ci, si, 1'b1, 1'b0, acc);
    chk("dir_accept", acc, 1'b1);
    for (int i = 0; i < STAGES - 1; i++) begin
      chk("latency_early", out_valid, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    end
    chk("latency_due", out_valid, 1'b1);
    chk("dir_sum", sum, es);
    chk("dir_cout", cout, ec);
    chk("dir_ovf", overflow, eo);
    chk("dir_cv", carry_vec, ecv);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic          acc;
    logic          ordy;
    int            idx;
    int            stall_left;
    int            d0;
    logic [63:0]   ra;
    logic [63:0]   rb;
    logic [DW-1:0] sa [4];
    logic [DW-1:0] sb [4];
    logic          sc [4];
    logic          ss [4];

    checks = 0; errors = 0; delivered = 0; prev_stall = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    prev_ov = 1'b0; prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0; prev_cv = '0;

    // Reset state.
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_cv", carry_vec, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed arithmetic cases.
    directed(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFE);
    directed(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'hFE);
    directed(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 8'h01);
    directed(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h03);
    directed(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h01);

    // Four mixed beats, 3-cycle stall once the first result appears.
    sa[0] = 8'h3C; sb[0] = 8'hC4; sc[0] = 1'b0; ss[0] = 1'b0;
    sa[1] = 8'h12; sb[1] = 8'h34; sc[1] = 1'b0; ss[1] = 1'b1;
    sa[2] = 8'h7F; sb[2] = 8'h7F; sc[2] = 1'b1; ss[2] = 1'b0;
    sa[3] = 8'h00; sb[3] = 8'h01; sc[3] = 1'b1; ss[3] = 1'b1;
    idx = 0; stall_left = 3; d0 = delivered;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() > 0); c++) begin
      ordy = 1'b1;
      if (out_valid && stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end
      cycle(idx < 4, sa[idx < 4 ? idx : 0], sb[idx < 4 ? idx : 0], sc[idx < 4 ? idx : 0],
            ss[idx < 4 ? idx : 0], ordy, 1'b0, acc);
      if (acc) idx++;
    end
    chk("stall_all_sent", idx, 4);
    chk("stall_stalls_done", stall_left, 0);
    chk("stall_delivered", delivered - d0, 4);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Reset with two beats in flight; the beat presented with rst is dropped.
    cycle(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, 8'h00);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_cv", carry_vec, 8'h00);
    chk("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      chk("no_stale", out_valid, 1'b0);
    end

    // Random regression with random handshakes.
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      cycle($urandom_range(0, 9) < 7, ra[DW-1:0], rb[DW-1:0], 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, 1'b0, acc);
    end

    // Bounded drain.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
